serial_addsub_ctrl: RTL
=======================

Name: serial_addsub_ctrl

Overview:
- Bit-serial add/subtract controller that runs N-bit two's-complement operations through a single 1-bit full-adder slice, one bit per clock, LSB first.
- The slice is the team's NAND-only full adder (Sum, Cout, Overflow = Cout xor Cin), instantiated once inside this block.
- Provides a start/done handshake, sequencing FSM, carry register and result, carry and overflow flag capture.
- Sits between a requester (ALU sequencer / testbench) and the shared adder slice.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 2..32.
- CNT_W, $clog2(WIDTH), width of the internal bit counter; derived, do not override.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request strobe; sampled only in IDLE.
- sub  input  1  0 = A+B, 1 = A-B; sampled with start.
- a  input  WIDTH  operand A; sampled with start.
- b  input  WIDTH  operand B; sampled with start.
- busy  output  1  high while the operation is in progress (RUN state).
- done  output  1  one-cycle completion pulse.
- result  output  WIDTH  sum or difference; updated only at completion.
- cout  output  1  carry out of the MSB; for subtract, 1 = no borrow (A >= B unsigned).
- overflow  output  1  signed overflow, taken from the MSB-slice Overflow output.

Behaviour:
- Reset (rst=1 at a rising edge) forces:
  - state to IDLE;
  - busy=0, done=0, result=0, cout=0, overflow=0;
  - internal shift registers, carry and counter to 0.
- Reset takes priority over all other inputs in every state. Reset during RUN aborts the operation; no done pulse follows.
- FSM states are IDLE, RUN and DONE. Encoding is free; unreachable encodings go to IDLE.
- IDLE:
  - When start=1 at an edge, latch a into shift register SA and (b xor {WIDTH{sub}}) into SB.
  - Set carry=sub, counter=0 and go to RUN.
  - When start=0, stay in IDLE; all outputs hold.
- RUN (busy=1):
  - Each edge feeds SA[0], SB[0] and carry into the slice.
  - The slice Sum shifts into the MSB of the partial-result register SR.
  - SA and SB shift right, carry takes the slice Cout, and counter increments.
  - On the edge where counter==WIDTH-1:
    - copy the shifted SR into result;
    - copy the slice Cout into cout and the slice Overflow into overflow;
    - go to DONE.
- DONE: done=1, busy=0 for exactly one cycle, then go to IDLE unconditionally.
- Latency: start is sampled at edge E0; RUN covers edges E1..E_WIDTH. done is high in the cycle after E_WIDTH, which is WIDTH+1 cycles after start is sampled. Result and flags are valid from that cycle.
- Throughput: a new start is accepted no earlier than the cycle after done, so one operation takes WIDTH+2 cycles.
- start while busy=1 or done=1 is ignored: no queuing and no operand change.
- result, cout and overflow hold their last values until the next completion or reset. They never show partial values during RUN.
- Arithmetic:
  - result = (A + B + 0) mod 2^WIDTH when sub=0.
  - result = (A + ~B + 1) mod 2^WIDTH when sub=1.
  - overflow = carry-in xor carry-out of the MSB.

Test Plan:
- Reset, then idle 3 cycles -> busy=0, done=0, result=0x00, cout=0, overflow=0; start=0 causes no change.
- WIDTH=8, a=0x64, b=0x1B, sub=0 -> done after exactly 9 cycles; result=0x7F, cout=0, overflow=0.
- a=0x7F, b=0x01, sub=0 -> result=0x80, cout=0, overflow=1. Then a=0xFF, b=0x01, sub=0 -> result=0x00, cout=1, overflow=0.
- a=0x05, b=0x03, sub=1 -> result=0x02, cout=1. Then a=0x03, b=0x05, sub=1 -> result=0xFE, cout=0. Then a=0x80, b=0x01, sub=1 -> result=0x7F, overflow=1.
- Start a=0x10, b=0x20; pulse start with a=0xFF, b=0xFF at cycle 3 of RUN -> second request ignored; result=0x30, single done pulse.
- Start an operation; assert rst at cycle 4 of RUN -> next cycle busy=0 and all outputs 0, no done pulse. A fresh start then completes normally (0x01+0x01 -> 0x02).

Source files
------------

// File: rtl/serial_addsub_ctrl.sv
// Bit-serial two's-complement add/subtract controller driving one shared NAND-only
// full-adder slice, one bit per clock, LSB first, with a start/done handshake.

module nand_full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout,
    output logic overflow
);
    logic n1_s, n2_s, n3_s, x1_s, n4_s, n5_s, n6_s;
    logic o1_s, o2_s, o3_s;

    assign n1_s = ~(a & b);
    assign n2_s = ~(a & n1_s);
    assign n3_s = ~(b & n1_s);
    assign x1_s = ~(n2_s & n3_s);
    assign n4_s = ~(x1_s & cin);
    assign n5_s = ~(x1_s & n4_s);
    assign n6_s = ~(cin & n4_s);
    assign sum  = ~(n5_s & n6_s);
    assign cout = ~(n1_s & n4_s);

    // Overflow is cout xor cin; only meaningful when this slice handles the MSB.
    assign o1_s     = ~(cout & cin);
    assign o2_s     = ~(cout & o1_s);
    assign o3_s     = ~(cin & o1_s);
    assign overflow = ~(o2_s & o3_s);
endmodule

module serial_addsub_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             overflow
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state_r;
    state_t           state_next_s;
    logic             busy_r;
    logic             done_r;
    logic             busy_next_s;
    logic             done_next_s;
    logic [WIDTH-1:0] sa_r;
    logic [WIDTH-1:0] sb_r;
    logic [WIDTH-1:0] sr_r;
    logic [WIDTH-1:0] sr_shift_s;
    logic             carry_r;
    logic [CNT_W-1:0] cnt_r;
    logic             last_s;
    logic [WIDTH-1:0] result_r;
    logic             cout_r;
    logic             overflow_r;
    logic             fa_sum_s;
    logic             fa_cout_s;
    logic             fa_ovf_s;

    nand_full_adder u_slice (
        .a        (sa_r[0]),
        .b        (sb_r[0]),
        .cin      (carry_r),
        .sum      (fa_sum_s),
        .cout     (fa_cout_s),
        .overflow (fa_ovf_s)
    );

    assign last_s     = (cnt_r == CNT_LAST);
    assign sr_shift_s = {fa_sum_s, sr_r[WIDTH-1:1]};

    // State register; busy/done are registered from the next-state decode.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            busy_r  <= busy_next_s;
            done_r  <= done_next_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next_s = IDLE;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_next_s = RUN;
                end else begin
                    state_next_s = IDLE;
                end
            end
            RUN: begin
                if (last_s) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = RUN;
                end
            end
            DONE:    state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // Output decode of the upcoming state.
    always_comb begin
        busy_next_s = 1'b0;
        done_next_s = 1'b0;
        case (state_next_s)
            RUN:  busy_next_s = 1'b1;
            DONE: done_next_s = 1'b1;
            default: begin
                busy_next_s = 1'b0;
                done_next_s = 1'b0;
            end
        endcase
    end

    // Operand shifting, carry chain and result/flag capture on the final bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            sa_r       <= {WIDTH{1'b0}};
            sb_r       <= {WIDTH{1'b0}};
            sr_r       <= {WIDTH{1'b0}};
            carry_r    <= 1'b0;
            cnt_r      <= {CNT_W{1'b0}};
            result_r   <= {WIDTH{1'b0}};
            cout_r     <= 1'b0;
            overflow_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        sa_r    <= a;
                        sb_r    <= b ^ {WIDTH{sub}};
                        carry_r <= sub;
                        cnt_r   <= {CNT_W{1'b0}};
                    end
                end
                RUN: begin
                    sa_r    <= {1'b0, sa_r[WIDTH-1:1]};
                    sb_r    <= {1'b0, sb_r[WIDTH-1:1]};
                    sr_r    <= sr_shift_s;
                    carry_r <= fa_cout_s;
                    cnt_r   <= cnt_r + CNT_ONE;
                    if (last_s) begin
                        result_r   <= sr_shift_s;
                        cout_r     <= fa_cout_s;
                        overflow_r <= fa_ovf_s;
                    end
                end
                default: begin
                    carry_r <= carry_r;
                end
            endcase
        end
    end

    assign busy     = busy_r;
    assign done     = done_r;
    assign result   = result_r;
    assign cout     = cout_r;
    assign overflow = overflow_r;
endmodule
